// File: rtl/fp_reg_read.sv
// FP register file with pending-write scoreboard and a one-entry registered operand stage.
// Define FP_REG_READ_BYPASS_EN to forward same-cycle writeback data to requested operands.
module fp_reg_read (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_ID_Read_Floating,
    input  logic [4:0]  in_ID_Read_Address_1,
    input  logic [4:0]  in_ID_Read_Address_2,
    input  logic        in_ID_Dest_Floating,
    input  logic [4:0]  in_ID_Dest_Address,
    input  logic        in_EX_Ready,
    input  logic        in_WB_Write_Floating,
    input  logic [4:0]  in_WB_Write_Address,
    input  logic [31:0] in_WB_Write_Data,
    output logic        out_Read_Valid,
    output logic [31:0] out_Read_Data_1,
    output logic [31:0] out_Read_Data_2,
    output logic        out_Stall
);

    localparam logic [31:0] FpInitVal = 32'h3F99999A;

    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    state_e      state_q, state_d;
    logic [31:0] rf_q [32];
    logic [31:0] pending_q, pending_d;
    logic [31:0] data1_q, data2_q;

    logic        byp1, byp2;
    logic        src1_busy, src2_busy, dest_busy, hazard, accept;
    logic [31:0] rd_data1, rd_data2;

`ifdef FP_REG_READ_BYPASS_EN
    assign byp1 = in_WB_Write_Floating && (in_WB_Write_Address == in_ID_Read_Address_1);
    assign byp2 = in_WB_Write_Floating && (in_WB_Write_Address == in_ID_Read_Address_2);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    // A source being written back this very cycle is no longer a hazard when forwarded.
    assign src1_busy = pending_q[in_ID_Read_Address_1] && !byp1;
    assign src2_busy = pending_q[in_ID_Read_Address_2] && !byp2;
    assign dest_busy = in_ID_Dest_Floating && pending_q[in_ID_Dest_Address];
    assign hazard    = src1_busy || src2_busy || dest_busy;

    assign accept    = in_ID_Read_Floating && !hazard && ((state_q == StEmpty) || in_EX_Ready);
    assign out_Stall = in_ID_Read_Floating && !accept;

    assign rd_data1 = byp1 ? in_WB_Write_Data : rf_q[in_ID_Read_Address_1];
    assign rd_data2 = byp2 ? in_WB_Write_Data : rf_q[in_ID_Read_Address_2];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: if (accept) state_d = StFull;
            StFull:  if (in_EX_Ready && !accept) state_d = StEmpty;
            default: state_d = StEmpty;
        endcase
    end

    // Clear first so an issue to the same register on this edge keeps it pending.
    always_comb begin
        pending_d = pending_q;
        if (in_WB_Write_Floating) pending_d[in_WB_Write_Address] = 1'b0;
        if (accept && in_ID_Dest_Floating) pending_d[in_ID_Dest_Address] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StEmpty;
            pending_q <= '0;
            data1_q   <= '0;
            data2_q   <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            if (accept) begin
                data1_q <= rd_data1;
                data2_q <= rd_data2;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
            rf_q[1] <= FpInitVal;
            rf_q[2] <= FpInitVal;
        end else if (in_WB_Write_Floating) begin
            rf_q[in_WB_Write_Address] <= in_WB_Write_Data;
        end
    end

    assign out_Read_Valid  = (state_q == StFull);
    assign out_Read_Data_1 = data1_q;
    assign out_Read_Data_2 = data2_q;

endmodule

// File: tb/tb_fp_reg_read.sv
// Directed bench for fp_reg_read; expectations adapt to FP_REG_READ_BYPASS_EN.
module tb_fp_reg_read;

    localparam logic [31:0] H = 32'h3F99999A;
`ifdef FP_REG_READ_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_fp;
    logic [4:0]  ra1, ra2;
    logic        dst_fp;
    logic [4:0]  dst;
    logic        ex_rdy;
    logic        wb_we;
    logic [4:0]  wb_a;
    logic [31:0] wb_d;
    logic        valid;
    logic [31:0] d1, d2;
    logic        stall;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fp_reg_read dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .in_ID_Read_Floating  (rd_fp),
        .in_ID_Read_Address_1 (ra1),
        .in_ID_Read_Address_2 (ra2),
        .in_ID_Dest_Floating  (dst_fp),
        .in_ID_Dest_Address   (dst),
        .in_EX_Ready          (ex_rdy),
        .in_WB_Write_Floating (wb_we),
        .in_WB_Write_Address  (wb_a),
        .in_WB_Write_Data     (wb_d),
        .out_Read_Valid       (valid),
        .out_Read_Data_1      (d1),
        .out_Read_Data_2      (d2),
        .out_Stall            (stall)
    );

    typedef struct packed {
        logic        rd;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic        dfp;
        logic [4:0]  da;
        logic        rdy;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        x_stall;
        logic        x_valid;
        logic [31:0] x_d1;
        logic [31:0] x_d2;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rd_fp = v.rd; ra1 = v.a1; ra2 = v.a2; dst_fp = v.dfp; dst = v.da;
        ex_rdy = v.rdy; wb_we = v.we; wb_a = v.wa; wb_d = v.wd;
    endtask

    // Inputs change on the falling edge; stall is sampled just before the rising edge.
    task automatic run_vec(input vec_t v, input string nm);
        @(negedge clk);
        drive(v);
        #2;
        check({nm, ".stall"}, {31'b0, stall}, {31'b0, v.x_stall});
        @(posedge clk);
        #1;
        check({nm, ".valid"}, {31'b0, valid}, {31'b0, v.x_valid});
        check({nm, ".d1"}, d1, v.x_d1);
        check({nm, ".d2"}, d2, v.x_d2);
    endtask

    vec_t tbl [10];
    vec_t v;

    initial begin
        rst_n = 1'b0;
        v = '0;
        drive(v);

        //         rd  a1 a2 dfp da rdy we wa wd            st v  d1            d2
        tbl[0] = '{1'b1, 5'd1,  5'd2,  1'b0, 5'd0, 1'b1, 1'b0, 5'd0,  32'h0,
                   1'b0, 1'b1, H, H};
        tbl[1] = '{1'b0, 5'd0,  5'd0,  1'b0, 5'd0, 1'b1, 1'b1, 5'd4,  32'h11111111,
                   1'b0, 1'b0, H, H};
        tbl[2] = '{1'b1, 5'd4,  5'd0,  1'b0, 5'd0, 1'b1, 1'b0, 5'd0,  32'h0,
                   1'b0, 1'b1, 32'h11111111, 32'h0};
        tbl[3] = '{1'b1, 5'd1,  5'd4,  1'b0, 5'd0, 1'b1, 1'b1, 5'd10, 32'hAAAA0010,
                   1'b0, 1'b1, H, 32'h11111111};
        tbl[4] = '{1'b1, 5'd10, 5'd0,  1'b0, 5'd0, 1'b1, 1'b1, 5'd11, 32'hBBBB0011,
                   1'b0, 1'b1, 32'hAAAA0010, 32'h0};
        tbl[5] = '{1'b1, 5'd11, 5'd10, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0,  32'h0,
                   1'b0, 1'b1, 32'hBBBB0011, 32'hAAAA0010};
        tbl[6] = '{1'b1, 5'd2,  5'd11, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0,  32'h0,
                   1'b0, 1'b1, H, 32'hBBBB0011};
        tbl[7] = '{1'b0, 5'd0,  5'd0,  1'b0, 5'd0, 1'b1, 1'b1, 5'd0,  32'hDEADBEEF,
                   1'b0, 1'b0, H, 32'hBBBB0011};
        tbl[8] = '{1'b1, 5'd0,  5'd0,  1'b0, 5'd0, 1'b1, 1'b0, 5'd0,  32'h0,
                   1'b0, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[9] = '{1'b0, 5'd0,  5'd0,  1'b0, 5'd0, 1'b1, 1'b0, 5'd0,  32'h0,
                   1'b0, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF};

        repeat (2) @(posedge clk);
        #1;
        check("reset.valid", {31'b0, valid}, 32'h0);
        check("reset.d1", d1, 32'h0);
        check("reset.d2", d2, 32'h0);
        check("reset.stall", {31'b0, stall}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

        // RAW hazard on f5 resolved by writeback.
        run_vec('{1'b1, 5'd1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 32'h0,
                  1'b0, 1'b1, H, H}, "raw.issue");
        run_vec('{1'b1, 5'd5, 5'd1, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,
                  1'b1, 1'b0, H, H}, "raw.stall1");
        run_vec('{1'b1, 5'd5, 5'd1, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,
                  1'b1, 1'b0, H, H}, "raw.stall2");
        run_vec('{1'b1, 5'd5, 5'd1, 1'b0, 5'd0, 1'b1, 1'b1, 5'd5, 32'h40000000,
                  !BYP, BYP, BYP ? 32'h40000000 : H, H}, "raw.wb");
        run_vec('{1'b1, 5'd5, 5'd1, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,
                  1'b0, 1'b1, 32'h40000000, H}, "raw.read");
        run_vec('{1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,
                  1'b0, 1'b0, 32'h40000000, H}, "raw.drain");

        // Downstream backpressure holds the operand stage.
        run_vec('{1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,
                  1'b0, 1'b1, H, H}, "bp.fill");
        for (int i = 0; i < 3; i++)
            run_vec('{1'b1, 5'd4, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0,
                      1'b1, 1'b1, H, H}, $sformatf("bp.hold%0d", i));
        run_vec('{1'b1, 5'd4, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,
                  1'b0, 1'b1, 32'h11111111, 32'hDEADBEEF}, "bp.release");
        run_vec('{1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,
                  1'b0, 1'b0, 32'h11111111, 32'hDEADBEEF}, "bp.drain");

        // Same-edge WB clear and issue set on f7: set must win.
        run_vec('{1'b1, 5'd1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b1, 5'd7, 32'h77777777,
                  1'b0, 1'b1, H, H}, "sw.issue");
        run_vec('{1'b1, 5'd7, 5'd1, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,
                  1'b1, 1'b0, H, H}, "sw.stall");
        run_vec('{1'b1, 5'd7, 5'd1, 1'b0, 5'd0, 1'b1, 1'b1, 5'd7, 32'h12345678,
                  !BYP, BYP, BYP ? 32'h12345678 : H, H}, "sw.wb");
        run_vec('{1'b1, 5'd7, 5'd1, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,
                  1'b0, 1'b1, 32'h12345678, H}, "sw.read");
        run_vec('{1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,
                  1'b0, 1'b0, 32'h12345678, H}, "sw.drain");

        // Reset while stalled on pending f3 with the output stage full.
        run_vec('{1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 32'h0,
                  1'b0, 1'b1, H, H}, "rst.issue");
        run_vec('{1'b1, 5'd3, 5'd1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0,
                  1'b1, 1'b1, H, H}, "rst.stall");
        @(negedge clk);
        #2;
        check("rst.pre_stall", {31'b0, stall}, 32'h1);
        check("rst.pre_valid", {31'b0, valid}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("rst.valid", {31'b0, valid}, 32'h0);
        check("rst.d1", d1, 32'h0);
        check("rst.stall", {31'b0, stall}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec('{1'b1, 5'd3, 5'd1, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,
                  1'b0, 1'b1, 32'h0, H}, "rst.read_f3");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
